// File: rtl/puf_keygen_ctrl.sv
// Arbiter-PUF key generation controller: repeated launch/recover evaluations of a
// shared challenge, per-bit majority vote, instability flags and a byte readout port.
module puf_keygen_ctrl #(
   parameter int N_PUF      = 40,
   parameter int CHAL_W     = 40,
   parameter int SETTLE_CYC = 19,
   parameter int N_EVAL     = 5,
   parameter int SEL_W      = 3
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic [CHAL_W-1:0] i_challenge_in,
   input  logic [N_PUF-1:0]  i_puf_resp,
   output logic [CHAL_W-1:0] o_chal_out,
   output logic              o_excite,
   output logic              o_busy,
   output logic              o_key_valid,
   output logic [N_PUF-1:0]  o_key,
   output logic [N_PUF-1:0]  o_unstable,
   input  logic [SEL_W-1:0]  i_byte_sel,
   output logic [7:0]        o_byte_out
);

   localparam int CNT_W  = $clog2(N_EVAL + 1);
   localparam int TMR_W  = $clog2(SETTLE_CYC);
   localparam int EVAL_W = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SETTLE_CYC - 1);
   localparam logic [EVAL_W-1:0] EVAL_LAST = EVAL_W'(N_EVAL - 1);
   localparam logic [CNT_W-1:0]  CNT_ALL   = CNT_W'(N_EVAL);
   localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(N_EVAL / 2);

   typedef enum logic [1:0] {IDLE, LAUNCH, RECOVER, DONE} state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [TMR_W-1:0]    r_timer;
   logic [EVAL_W-1:0]   r_evalCnt;
   logic [CNT_W-1:0]    r_onesCnt [N_PUF];
   logic [CHAL_W-1:0]   r_chal;
   logic                r_excite;
   logic                r_busy;
   logic                r_keyValid;
   logic [N_PUF-1:0]    r_key;
   logic [N_PUF-1:0]    r_unstable;
   logic [7:0]          r_byteOut;
   logic                w_timerDone;
   logic [N_PUF-1:0]    w_keyShift;

   assign w_timerDone = (r_timer == TMR_LAST);

   always_ff @(posedge Clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (i_start) w_stateNext = LAUNCH;
         LAUNCH:  if (w_timerDone) w_stateNext = RECOVER;
         RECOVER: if (w_timerDone) w_stateNext = (r_evalCnt == EVAL_LAST) ? DONE : LAUNCH;
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Excite is registered and toggled on the same edge that changes state, so the
   // line is low for exactly SETTLE_CYC cycles of each launch window.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         r_timer    <= '0;
         r_evalCnt  <= '0;
         r_chal     <= '1;
         r_excite   <= 1'b1;
         r_busy     <= 1'b0;
         r_keyValid <= 1'b0;
         r_key      <= '0;
         r_unstable <= '0;
         for (int i = 0; i < N_PUF; i++) r_onesCnt[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_chal     <= i_challenge_in;
                  r_keyValid <= 1'b0;
                  r_busy     <= 1'b1;
                  r_evalCnt  <= '0;
                  r_timer    <= '0;
                  r_excite   <= 1'b0;
                  for (int i = 0; i < N_PUF; i++) r_onesCnt[i] <= '0;
               end
            end
            LAUNCH: begin
               if (w_timerDone) begin
                  r_timer  <= '0;
                  r_excite <= 1'b1;
                  for (int i = 0; i < N_PUF; i++)
                     r_onesCnt[i] <= r_onesCnt[i] + CNT_W'(i_puf_resp[i]);
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            RECOVER: begin
               if (w_timerDone) begin
                  r_timer <= '0;
                  if (r_evalCnt != EVAL_LAST) begin
                     r_evalCnt <= r_evalCnt + 1'b1;
                     r_excite  <= 1'b0;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            DONE: begin
               for (int i = 0; i < N_PUF; i++) begin
                  r_key[i]      <= (r_onesCnt[i] > CNT_HALF);
                  r_unstable[i] <= (r_onesCnt[i] != '0) && (r_onesCnt[i] != CNT_ALL);
               end
               r_keyValid <= 1'b1;
               r_busy     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Shifting by whole bytes naturally yields zero for selects past the key width.
   assign w_keyShift = r_key >> {i_byte_sel, 3'b000};

   always_ff @(posedge Clk) begin
      if (!reset) r_byteOut <= '0;
      else        r_byteOut <= w_keyShift[7:0];
   end

   assign o_chal_out  = r_chal;
   assign o_excite    = r_excite;
   assign o_busy      = r_busy;
   assign o_key_valid = r_keyValid;
   assign o_key       = r_key;
   assign o_unstable  = r_unstable;
   assign o_byte_out  = r_byteOut;

endmodule

// File: tb/tb_puf_keygen_ctrl.sv
// Randomised self-checking bench for puf_keygen_ctrl; the reference model counts
// ones per bit over the applied evaluation samples and votes directly.
module tb_puf_keygen_ctrl;

   localparam int NP  = 40;
   localparam int CW  = 40;
   localparam int SC  = 19;
   localparam int NE  = 5;
   localparam int SW  = 3;
   localparam int LAT = 2 * NE * SC + 1;

   logic          Clk = 1'b0;
   logic          reset;
   logic          i_start;
   logic [CW-1:0] i_challenge_in;
   logic [NP-1:0] i_puf_resp;
   logic [CW-1:0] o_chal_out;
   logic          o_excite;
   logic          o_busy;
   logic          o_key_valid;
   logic [NP-1:0] o_key;
   logic [NP-1:0] o_unstable;
   logic [SW-1:0] i_byte_sel;
   logic [7:0]    o_byte_out;

   logic          s2Start;
   logic [63:0]   s2Chal;
   logic [63:0]   s2Resp;
   logic [63:0]   s2ChalOut;
   logic          s2Excite;
   logic          s2Busy;
   logic          s2KeyValid;
   logic [63:0]   s2Key;
   logic [63:0]   s2Unstable;
   logic [2:0]    s2ByteSel;
   logic [7:0]    s2ByteOut;

   int            nCompared   = 0;
   int            nMismatched = 0;
   logic [NP-1:0] samp [NE];

   always #5 Clk = ~Clk;

   puf_keygen_ctrl #(.N_PUF(NP), .CHAL_W(CW), .SETTLE_CYC(SC), .N_EVAL(NE), .SEL_W(SW)) dut (
      .Clk(Clk), .reset(reset), .i_start(i_start), .i_challenge_in(i_challenge_in),
      .i_puf_resp(i_puf_resp), .o_chal_out(o_chal_out), .o_excite(o_excite),
      .o_busy(o_busy), .o_key_valid(o_key_valid), .o_key(o_key), .o_unstable(o_unstable),
      .i_byte_sel(i_byte_sel), .o_byte_out(o_byte_out)
   );

   puf_keygen_ctrl #(.N_PUF(64), .CHAL_W(64), .SETTLE_CYC(4), .N_EVAL(3), .SEL_W(3)) dut2 (
      .Clk(Clk), .reset(reset), .i_start(s2Start), .i_challenge_in(s2Chal),
      .i_puf_resp(s2Resp), .o_chal_out(s2ChalOut), .o_excite(s2Excite),
      .o_busy(s2Busy), .o_key_valid(s2KeyValid), .o_key(s2Key), .o_unstable(s2Unstable),
      .i_byte_sel(s2ByteSel), .o_byte_out(s2ByteOut)
   );

   function automatic logic [39:0] rand40();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[39:0];
   endfunction

   // One full key request. resetAt >= 0 aborts the run with reset after that edge;
   // pulseAt >= 0 re-pulses start mid-run; holdStart keeps start high through DONE.
   task automatic doRun(input logic [CW-1:0] chal, input int resetAt, input int pulseAt,
                        input logic holdStart, input logic [CW-1:0] chal2, input string tag);
      int            firstKv = -1;
      int            exErr = 0, busyErr = 0, chalErr = 0, ones;
      logic          expEx;
      logic [NP-1:0] expKey, expUns;
      for (int b = 0; b < NP; b++) begin
         ones = 0;
         for (int e = 0; e < NE; e++) ones += int'(samp[e][b]);
         expKey[b] = (2 * ones > NE);
         expUns[b] = (ones != 0) && (ones != NE);
      end
      i_start = 1'b1;
      i_challenge_in = chal;
      i_puf_resp = samp[0];
      for (int k = 0; k < LAT + 10; k++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (o_key_valid) begin
            firstKv = k;
            break;
         end
         if (o_chal_out !== chal) chalErr++;
         expEx = (k >= 2 * NE * SC) ? 1'b1 : logic'((k / SC) % 2);
         if (o_excite !== expEx) exErr++;
         if (o_busy !== 1'b1) busyErr++;
         if (k == resetAt) begin
            reset = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            nCompared += 4;
            if (o_excite !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s rst_excite got %b want 1", tag, o_excite); end
            if (o_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s rst_busy got %b want 0", tag, o_busy); end
            if (o_key_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s rst_valid got %b want 0", tag, o_key_valid); end
            if (o_key !== '0) begin nMismatched++; $display("[TB] FAIL %s rst_key got %h want 0", tag, o_key); end
            reset = 1'b1;
            i_start = 1'b0;
            return;
         end
         if (k == 0) i_challenge_in = chal2;
         i_start = holdStart || (k == pulseAt);
         i_puf_resp = samp[(k / (2 * SC) < NE) ? k / (2 * SC) : NE - 1];
      end
      nCompared += 8;
      if (firstKv !== LAT) begin nMismatched++; $display("[TB] FAIL %s latency got %0d want %0d", tag, firstKv, LAT); end
      if (exErr != 0) begin nMismatched++; $display("[TB] FAIL %s excite_wave bad_cycles %0d want 0", tag, exErr); end
      if (busyErr != 0) begin nMismatched++; $display("[TB] FAIL %s busy_run bad_cycles %0d want 0", tag, busyErr); end
      if (chalErr != 0) begin nMismatched++; $display("[TB] FAIL %s chal_hold bad_cycles %0d want 0", tag, chalErr); end
      if (o_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s busy_done got %b want 0", tag, o_busy); end
      if (o_key !== expKey) begin nMismatched++; $display("[TB] FAIL %s key got %h want %h", tag, o_key, expKey); end
      if (o_unstable !== expUns) begin nMismatched++; $display("[TB] FAIL %s unstable got %h want %h", tag, o_unstable, expUns); end
      if (o_chal_out !== chal) begin nMismatched++; $display("[TB] FAIL %s chal_done got %h want %h", tag, o_chal_out, chal); end
      if (holdStart) begin
         @(posedge Clk);
         @(negedge Clk);
         nCompared += 3;
         if (o_key_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s restart_valid got %b want 0", tag, o_key_valid); end
         if (o_busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s restart_busy got %b want 1", tag, o_busy); end
         if (o_chal_out !== chal2) begin nMismatched++; $display("[TB] FAIL %s restart_chal got %h want %h", tag, o_chal_out, chal2); end
         i_start = 1'b0;
         reset = 1'b0;
         @(posedge Clk);
         @(negedge Clk);
         reset = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      nCompared += 7;
      if (o_excite !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_excite got %b want 1", o_excite); end
      if (o_chal_out !== '1) begin nMismatched++; $display("[TB] FAIL reset_chal got %h want all ones", o_chal_out); end
      if (o_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
      if (o_key_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %b want 0", o_key_valid); end
      if (o_key !== '0) begin nMismatched++; $display("[TB] FAIL reset_key got %h want 0", o_key); end
      if (o_unstable !== '0) begin nMismatched++; $display("[TB] FAIL reset_unstable got %h want 0", o_unstable); end
      if (o_byte_out !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_byte got %h want 00", o_byte_out); end
      reset = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_constant();
      for (int e = 0; e < NE; e++) samp[e] = 40'h5A5A5A5A5A;
      doRun(40'hA5A5FFFFFF, -1, -1, 1'b0, 40'hA5A5FFFFFF, "constant");
   endtask

   task automatic test_readout();
      logic [7:0] expB;
      for (int s = 0; s < 8; s++) begin
         i_byte_sel = SW'(s);
         @(posedge Clk);
         @(negedge Clk);
         expB = (s < NP / 8) ? 8'h5A : 8'h00;
         nCompared++;
         if (o_byte_out !== expB) begin nMismatched++; $display("[TB] FAIL readout sel=%0d got %h want %h", s, o_byte_out, expB); end
      end
      i_byte_sel = '0;
   endtask

   task automatic test_bit0_votes();
      for (int e = 0; e < NE; e++) samp[e] = {39'h2D2D2D2D2D, logic'(e == 1 || e == 3)};
      doRun(rand40(), -1, -1, 1'b0, rand40(), "bit0_two_of_five");
      for (int e = 0; e < NE; e++) samp[e] = {39'h2D2D2D2D2D, logic'(e % 2 == 0)};
      doRun(rand40(), -1, -1, 1'b0, rand40(), "bit0_three_of_five");
   endtask

   task automatic test_random();
      logic [NP-1:0] base;
      for (int r = 0; r < 4; r++) begin
         base = rand40();
         for (int e = 0; e < NE; e++) samp[e] = base ^ (rand40() & rand40() & rand40());
         doRun(rand40(), -1, -1, 1'b0, rand40(), $sformatf("random%0d", r));
      end
   endtask

   task automatic test_reset_mid();
      for (int e = 0; e < NE; e++) samp[e] = rand40() | 40'h1;
      doRun(rand40(), 80, -1, 1'b0, rand40(), "reset_mid");
      @(negedge Clk);
      for (int e = 0; e < NE; e++) samp[e] = rand40();
      doRun(rand40(), -1, -1, 1'b0, rand40(), "after_reset");
   endtask

   task automatic test_back_to_back();
      for (int e = 0; e < NE; e++) samp[e] = rand40();
      doRun(40'h1122334455, -1, 50, 1'b0, 40'h99AABBCCDD, "start_ignored");
      for (int e = 0; e < NE; e++) samp[e] = rand40();
      doRun(40'h0F0F0F0F0F, -1, -1, 1'b1, 40'hF0F0F0F0F0, "start_held");
   endtask

   task automatic test_params();
      int firstKv = -1;
      s2ByteSel = 3'd7;
      s2Resp = 64'h0123456789ABCDEF;
      s2Chal = 64'hDEADBEEFCAFEF00D;
      s2Start = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(posedge Clk);
         @(negedge Clk);
         s2Start = 1'b0;
         if (s2KeyValid) begin
            firstKv = k;
            break;
         end
      end
      @(posedge Clk);
      @(negedge Clk);
      nCompared += 5;
      if (firstKv !== 25) begin nMismatched++; $display("[TB] FAIL p2_latency got %0d want 25", firstKv); end
      if (s2Key !== 64'h0123456789ABCDEF) begin nMismatched++; $display("[TB] FAIL p2_key got %h want 0123456789abcdef", s2Key); end
      if (s2Unstable !== '0) begin nMismatched++; $display("[TB] FAIL p2_unstable got %h want 0", s2Unstable); end
      if (s2ByteOut !== 8'h01) begin nMismatched++; $display("[TB] FAIL p2_byte7 got %h want 01", s2ByteOut); end
      if (s2ChalOut !== 64'hDEADBEEFCAFEF00D) begin nMismatched++; $display("[TB] FAIL p2_chal got %h want deadbeefcafef00d", s2ChalOut); end
   endtask

   initial begin
      reset = 1'b0;
      i_start = 1'b0;
      i_challenge_in = '0;
      i_puf_resp = '0;
      i_byte_sel = '0;
      s2Start = 1'b0;
      s2Chal = '0;
      s2Resp = '0;
      s2ByteSel = '0;
      @(negedge Clk);
      test_reset();
      test_constant();
      test_readout();
      test_bit0_votes();
      test_random();
      test_reset_mid();
      test_back_to_back();
      test_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/puf_keygen_ctrl.md
Name: puf_keygen_ctrl

Overview:
Parametrised controller for an external array of N_PUF delay-based arbiter PUF cells that share one challenge and one excite line.
- Per request: latches a challenge, then runs N_EVAL launch/recover cycles on the excite line with a programmable settle time.
- Samples the PUF response vector on every evaluation and majority-votes each bit into a stable key.
- Flags bits that were not unanimous and exposes the key through a registered byte-select readout port for LED/debug or downstream crypto.

Parameters:
N_PUF, 40, number of PUF cells = key width in bits (multiple of 8)
CHAL_W, 40, challenge width in bits
SETTLE_CYC, 19, cycles excite is held low (launch) and then high (recover) per evaluation; >=2
N_EVAL, 5, evaluations per key; odd, >=1
SEL_W, 3, width of byte_sel; 2^SEL_W >= N_PUF/8

Ports:
Clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  request key generation; sampled in IDLE only
challenge_in  in  CHAL_W  challenge, captured on accepted start
puf_resp  in  N_PUF  response bits from PUF array (synchronised externally)
chal_out  out  CHAL_W  challenge driven to all PUF cells
excite  out  1  shared excite line; 1 = idle/precharge, 0 = launch
busy  out  1  high from accepted start until key_valid rises
key_valid  out  1  level; high when key/unstable hold a completed result
key  out  N_PUF  majority-voted key
unstable  out  N_PUF  per-bit flag: 1 = bit not identical across all N_EVAL samples
byte_sel  in  SEL_W  byte index for readout
byte_out  out  8  key[8*byte_sel +: 8], registered

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; excite=1; chal_out=all ones; busy=0; key_valid=0; key=0; unstable=0; byte_out=0.
  - All per-bit counters, eval and settle counters cleared.
  - Reset has priority over every other event, including mid-operation; an interrupted run produces no result.
- States: IDLE, LAUNCH, RECOVER, DONE.
- IDLE:
  - On start==1: chal_out<=challenge_in, per-bit counters cleared, key_valid<=0, busy<=1, eval_cnt<=0, timer<=0; next state LAUNCH.
  - start==0: hold all outputs.
- LAUNCH:
  - excite=0 (registered, so low from the edge that enters LAUNCH); timer increments each cycle.
  - On the edge where timer==SETTLE_CYC-1: each ones_cnt[i] += puf_resp[i]; timer<=0; next state RECOVER.
  - Exactly SETTLE_CYC cycles low per evaluation.
- RECOVER:
  - excite=1 for SETTLE_CYC cycles.
  - At the end: if eval_cnt==N_EVAL-1, go to DONE; else eval_cnt++ and go to LAUNCH.
- DONE, one cycle:
  - key[i]<=(ones_cnt[i] > N_EVAL/2).
  - unstable[i]<=(ones_cnt[i]!=0 && ones_cnt[i]!=N_EVAL).
  - key_valid<=1; busy<=0; next state IDLE.
- Counter widths: ones_cnt is clog2(N_EVAL+1) bits and cannot overflow. timer is clog2(SETTLE_CYC) bits. eval_cnt is clog2(N_EVAL) bits (min 1).
- Latency: start sampled at edge 0; key_valid high after edge 2*N_EVAL*SETTLE_CYC+1 (191 with defaults).
- chal_out is constant from edge 0 until the next accepted start.
- start while busy: ignored, no queuing. start asserted in the same cycle key_valid rises is not accepted (state is DONE); it is accepted on the next cycle if still high.
- New run: key and unstable keep their old values until the next DONE, but key_valid drops on the accepted start.
- Readout: byte_out<=key[8*byte_sel +: 8] every cycle, one-cycle latency. byte_sel >= N_PUF/8 gives byte_out<=0. Readout works regardless of key_valid.
- N_EVAL==1: unstable is always 0; key equals the single sample.

Test Plan:
- Defaults, puf_resp constant 40'h5A5A5A5A5A, start with challenge_in=40'hA5A5FFFFFF -> chal_out=40'hA5A5FFFFFF from edge 0; excite low exactly 19 cycles, then high 19, five times; key_valid at edge 191; key=40'h5A5A5A5A5A; unstable=0.
- Same run, but puf_resp bit 0 forced to 1 in evaluations 1 and 3, 0 otherwise -> key[0]=0, unstable=40'h1. Then bit 0 =1 in three of five evals -> key[0]=1, unstable[0]=1.
- After the first scenario: byte_sel=0..4 -> byte_out=8'h5A one cycle after each change; byte_sel=5,6,7 -> byte_out=8'h00.
- reset driven low during 3rd LAUNCH -> next edge: excite=1, busy=0, key_valid=0, key=0. A new start then completes in 191 cycles with a correct key.
- start pulsed again at edge 50 of a run with a different challenge_in -> ignored: chal_out unchanged, key_valid still at edge 191. start held high through DONE -> second run begins the cycle after key_valid rises, and key_valid falls with it.
- Params N_PUF=64, CHAL_W=64, N_EVAL=3, SETTLE_CYC=4, SEL_W=3, puf_resp=64'h0123456789ABCDEF -> key_valid at edge 25; byte_sel=7 gives 8'h01.
